uart_tx_engine: RTL
===================

# uart_tx_engine

Transmit half of the UART peripheral, the write-side counterpart to the port address decoder. The processor writes a data byte to the TX data port; the decoded write strobe for that port loads this block. The block then serialises the byte as one fixed 11-bit-time asynchronous frame on `tx` and signals completion to the processor through `txrdy`, which the status read port exposes.

## Interface
- No parameters. Baud rate and frame format are run-time inputs.
- `clk`  in  1  system clock. One clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  one-cycle write strobe from the address decoder (TX data port).
- `out_port`  in  8  processor output data; sampled when `load` is accepted.
- `eight`  in  1  1 = 8 data bits, 0 = 7 data bits.
- `pen`  in  1  parity enable.
- `ohel`  in  1  parity sense: 0 = even, 1 = odd.
- `baud_k`  in  19  clocks per bit time; a value of 0 is treated as 1.
- `tx`  out  1  serial line, idle high.
- `txrdy`  out  1  1 = idle and able to accept `load`.

## Operation
- States: IDLE and SHIFT.
- **IDLE**
  - `tx` = 1 and `txrdy` = 1.
  - `load` = 1 latches `out_port`, `eight`, `pen`, `ohel` and `baud_k` into an 11-bit frame register and moves the block to SHIFT.
- **Frame content (LSB first, always 11 bit times)**
  - Bit 0 is the start bit (0).
  - eight=1, pen=1: D0–D7, parity, 1 stop.
  - eight=1, pen=0: D0–D7, 2 stops.
  - eight=0, pen=1: D0–D6, parity, 2 stops.
  - eight=0, pen=0: D0–D6, 3 stops.
- **Parity**: XOR of the transmitted data bits (7 or 8), inverted when `ohel`=1.
- **SHIFT**
  - `txrdy` = 0.
  - A 19-bit bit-time counter runs from 0 to `baud_k`−1.
  - At terminal count, the frame register shifts right with 1 filling in, and the 4-bit bit counter increments.
  - After bit 10 completes, the block returns to IDLE.
- **Boundary conditions**
  - `load` during SHIFT is ignored. It has no effect on data, config or counters.
  - Config inputs that change mid-frame have no effect. Only the values latched at load are used.
  - `reset` asserted in any state forces IDLE at the next edge: `tx`=1, `txrdy`=1, both counters 0, frame register all ones. A frame cut short by reset is not resumed.
  - `load` and `reset` in the same cycle: reset wins.
- **Reset values**: `tx`=1, `txrdy`=1.

## Timing
- Both outputs are registered.
- `load` sampled at edge N → at edge N, `txrdy` goes 0 and `tx` goes 0 (start bit). The start bit is visible from cycle N+1.
- Each bit is held for exactly max(`baud_k`,1) clocks.
- The full frame lasts 11·max(`baud_k`,1) clocks.
- At the edge that ends bit 10, `tx`=1 and `txrdy`=1 together.
- A `load` in that same cycle sees `txrdy`=0 and is ignored. The earliest accepted `load` is one cycle later.
- Back-to-back frames therefore have no idle gap beyond that one cycle plus the stop bits already in the frame.

## Structure
- Shared package `uart_pkg`:
  - `FRAME_BITS` = 11.
  - `BAUD_W` = 19.
  - state enum {IDLE, SHIFT}.
  - The parity function, reused by the receiver for checking.
- One sub-module, `uart_bit_timer`:
  - Inputs: `clk`, `reset`, `enable`, `baud_k`.
  - Output: one-cycle `bit_done` pulse.
  - Reused by the receiver.
- Frame assembly, shift register and bit counter stay in the top module.

## Test plan
- Reset: assert `reset` for 3 cycles → `tx`=1 and `txrdy`=1 with no toggling for 100 cycles.
- `out_port`=0x55, eight=1, pen=1, ohel=0, `baud_k`=4, one `load` → `tx` = 0,1,0,1,0,1,0,1,0,0,1, each bit held 4 cycles. `txrdy` is low for exactly 44 cycles.
- `out_port`=0xA3, eight=1, pen=1, ohel=1, `baud_k`=3 → parity bit = 1 and the frame lasts 33 cycles. With eight=0, pen=0 and 0x41 → `tx` = 0,1,0,0,0,0,0,1,1,1,1.
- `load` of 0x55 followed by a `load` of 0xFF at cycle 10 and at the `txrdy`-rising cycle → both later loads are ignored. The line carries an unaltered 0x55 frame, and only a `load` one cycle after `txrdy` rises starts a new frame.
- `reset` at cycle 20 of a `baud_k`=4 frame → `tx`=1 and `txrdy`=1 at the next edge. A `load` of 0x0F two cycles later produces a clean full frame.
- `baud_k`=0 with `out_port`=0x00, eight=1, pen=0 → bits last 1 cycle each and the frame is 11 cycles: 0×9 then 1,1.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit and receive engines: frame and
// baud-counter widths, the engine state type and the parity function.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Every frame occupies this many bit times, whatever the data/parity format.
    localparam int FRAME_BITS = 11;
    // Width of the clocks-per-bit setting and of the bit-time counter.
    localparam int BAUD_W     = 19;
    // Width of the bit-within-frame counter (holds 0..FRAME_BITS-1).
    localparam int BITCNT_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } uart_state_e;

    // Parity over the 7 or 8 data bits on the line; odd sense inverts it.
    // The receiver calls this with the captured byte to check a frame.
    function automatic logic parity(
        input logic [7:0] data,
        input logic       eight,
        input logic       odd
    );
        logic [7:0] bits;
        bits = eight ? data : {1'b0, data[6:0]};
        return (^bits) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Counts clocks within one bit time and pulses bit_done on the last clock of
// each bit. The counter holds at zero while disabled, so the first bit after
// enable rises is always a full bit time long.
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   enable    in   1 = count; 0 = hold counter at zero
//   baud_k    in   clocks per bit time (0 behaves as 1)
//   bit_done  out  one-cycle pulse on the final clock of a bit time
// ---------------------------------------------------------------------------
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [BAUD_W-1:0] baud_k,
    output logic              bit_done
);

    logic [BAUD_W-1:0] cnt_q;
    logic [BAUD_W-1:0] cnt_d;
    logic [BAUD_W-1:0] last_cnt;

    always_comb begin
        // NOTE: every signal written here gets a value before any branch so no
        // path can leave one unassigned and infer a latch.
        last_cnt = '0;
        cnt_d    = '0;
        // A setting of 0 collapses to one clock per bit, same as a setting of 1.
        if (baud_k != '0) begin
            last_cnt = baud_k - BAUD_W'(1);
        end
        bit_done = enable && (cnt_q == last_cnt);
        if (enable && !bit_done) begin
            cnt_d = cnt_q + BAUD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
// Transmit half of the UART. A write strobe in IDLE captures the byte and the
// frame format into an 11-bit frame register (start bit in bit 0) plus the
// baud setting; the register then shifts right once per bit time, filling
// with ones, so the line returns to the idle level on its own. tx is the
// frame register LSB, hence registered.
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   load      in   one-cycle write strobe for the TX data port
//   out_port  in   data byte, captured when load is accepted
//   eight     in   1 = 8 data bits, 0 = 7 data bits
//   pen       in   parity enable
//   ohel      in   parity sense: 0 = even, 1 = odd
//   baud_k    in   clocks per bit time (0 behaves as 1)
//   tx        out  serial line, idle high
//   txrdy     out  1 = idle, a load will be accepted
// ---------------------------------------------------------------------------
module uart_tx_engine
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [7:0]        out_port,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic [BAUD_W-1:0] baud_k,
    output logic              tx,
    output logic              txrdy
);

    uart_state_e             state_q,   state_d;
    logic [FRAME_BITS-1:0]   frame_q,   frame_d;
    logic [BITCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0]       baud_q,    baud_d;
    logic                    txrdy_q,   txrdy_d;

    logic                    bit_done;
    logic                    par_bit;
    logic                    bit8;
    logic                    bit9;
    logic [FRAME_BITS-1:0]   load_frame;

    // Frame assembly from the live inputs; only used on the accepting edge.
    // Bits 8 and 9 carry D7/parity/stop depending on the format; bit 10 is
    // always a stop bit.
    assign par_bit    = parity(out_port, eight, ohel);
    assign bit8       = eight ? out_port[7] : (pen ? par_bit : 1'b1);
    assign bit9       = (eight && pen) ? par_bit : 1'b1;
    assign load_frame = {1'b1, bit9, bit8, out_port[6:0], 1'b0};

    // Timer runs from the latched baud so mid-frame changes to baud_k are inert.
    uart_bit_timer u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .enable   (state_q == SHIFT),
        .baud_k   (baud_q),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        txrdy_d   = txrdy_q;

        unique case (state_q)
            IDLE: begin
                txrdy_d = 1'b1;
                if (load) begin
                    frame_d   = load_frame;
                    baud_d    = baud_k;
                    bit_cnt_d = '0;
                    txrdy_d   = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // load is deliberately not looked at here.
                if (bit_done) begin
                    frame_d = {1'b1, frame_q[FRAME_BITS-1:1]};
                    if (bit_cnt_q == BITCNT_W'(FRAME_BITS - 1)) begin
                        bit_cnt_d = '0;
                        txrdy_d   = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            frame_q   <= '1;
            bit_cnt_q <= '0;
            baud_q    <= '0;
            txrdy_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
            txrdy_q   <= txrdy_d;
        end
    end

    assign tx    = frame_q[0];
    assign txrdy = txrdy_q;

endmodule
